// File: rtl/eeg_xram_bank_pkg.sv
// Shared definitions for the EEG external-RAM bank: read FIFO depth and the
// {dat,lst} entry carried through the read pipeline.
package eeg_xram_bank_pkg;

    // Entries in each channel's output FIFO
    localparam int XRAM_FIFO_DEPTH = 2;

    // Widest data word an entry can carry; channels use the low XRAM_DAT_DW bits
    localparam int XRAM_ENT_DW_MAX = 32;

    // One output FIFO entry: read data plus its last-of-burst flag
    typedef struct packed {
        logic [XRAM_ENT_DW_MAX-1:0] dat;
        logic                       lst;
    } xram_ent_t;

endpackage

// File: rtl/eeg_xram_bank_ram.sv
// 1R1W RAM primitive: synchronous write, registered read (data one cycle
// after the read enable). Contents are never cleared.
module eeg_xram_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem_r [2**AW];
    logic [DW-1:0] rd_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wa] <= wd;
        end
    end

    // Read port; a same-cycle write to ra is not visible here (old data)
    always_ff @(posedge clk) begin
        if (re) begin
            rd_r <= mem_r[ra];
        end
    end

    assign rd = rd_r;

endmodule

// File: rtl/eeg_xram_chn.sv
// One independent channel: RAM, read stage S1, 2-entry output FIFO and the
// optional write-to-read forwarding. In pass mode write data bypasses the RAM
// and flows through S1/FIFO in order.
module eeg_xram_chn
    import eeg_xram_bank_pkg::*;
#(
    parameter int AW      = 12,
    parameter int DW      = 8,
    parameter int RAW_FWD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pass_ena,
    input  logic          din_vld,
    output logic          din_rdy,
    input  logic [AW-1:0] din_add,
    input  logic [DW-1:0] din_dat,
    input  logic          add_vld,
    input  logic          add_lst,
    output logic          add_rdy,
    input  logic [AW-1:0] add_add,
    output logic          dat_vld,
    output logic          dat_lst,
    input  logic          dat_rdy,
    output logic [DW-1:0] dat_dat
);

    logic          pop_s, credit_s, rd_acc_s, wr_acc_s, pas_acc_s;
    logic          ram_we_s, ram_re_s, fwd_hit_s;
    logic [2:0]    occ_s;
    logic [DW-1:0] ram_rdat_s, s1_out_s;
    xram_ent_t     ent_s, head_s;

    logic          s1_vld_r, s1_lst_r, s1_byp_r;
    logic [DW-1:0] s1_dat_r;
    xram_ent_t     fifo_mem_r [XRAM_FIFO_DEPTH];
    logic          wr_ptr_r, rd_ptr_r;
    logic [1:0]    fifo_cnt_r;

    // Credit check, ready generation and RAM enable decode
    always_comb begin
        pop_s    = (fifo_cnt_r != 2'd0) & dat_rdy;
        occ_s    = {1'b0, fifo_cnt_r} + {2'b00, s1_vld_r} - {2'b00, pop_s};
        credit_s = (occ_s < 3'd2);
        if (!rst_n) begin
            add_rdy = 1'b0;
            din_rdy = 1'b0;
        end else if (pass_ena) begin
            add_rdy = 1'b0;
            din_rdy = credit_s;
        end else begin
            add_rdy = credit_s;
            din_rdy = 1'b1;
        end
        rd_acc_s  = add_vld & add_rdy;
        wr_acc_s  = din_vld & din_rdy;
        ram_we_s  = wr_acc_s & ~pass_ena;
        ram_re_s  = rd_acc_s;
        pas_acc_s = wr_acc_s & pass_ena;
        fwd_hit_s = (RAW_FWD != 0) && ram_we_s && rd_acc_s && (din_add == add_add);
    end

    eeg_xram_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk (clk),
        .we  (ram_we_s),
        .wa  (din_add),
        .wd  (din_dat),
        .re  (ram_re_s),
        .ra  (add_add),
        .rd  (ram_rdat_s)
    );

    // Stage S1: holds the accepted request while the RAM read completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            s1_lst_r <= 1'b0;
            s1_byp_r <= 1'b0;
            s1_dat_r <= {DW{1'b0}};
        end else begin
            s1_vld_r <= rd_acc_s | pas_acc_s;
            if (rd_acc_s) begin
                s1_lst_r <= add_lst;
                s1_byp_r <= fwd_hit_s;
                s1_dat_r <= din_dat;
            end else if (pas_acc_s) begin
                s1_lst_r <= 1'b0;
                s1_byp_r <= 1'b1;
                s1_dat_r <= din_dat;
            end
        end
    end

    // S1 data: forwarded/pass data overrides the RAM output
    always_comb begin
        if (s1_byp_r) begin
            s1_out_s = s1_dat_r;
        end else begin
            s1_out_s = ram_rdat_s;
        end
        ent_s            = '{dat: {XRAM_ENT_DW_MAX{1'b0}}, lst: s1_lst_r};
        ent_s.dat[DW-1:0] = s1_out_s;
    end

    // FIFO storage; a valid S1 entry always has room thanks to the credit rule
    always_ff @(posedge clk) begin
        if (rst_n && s1_vld_r) begin
            fifo_mem_r[wr_ptr_r] <= ent_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            if (s1_vld_r) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, s1_vld_r} - {1'b0, pop_s};
        end
    end

    // Output port from FIFO head; forced to zero while empty
    always_comb begin
        head_s  = fifo_mem_r[rd_ptr_r];
        dat_vld = (fifo_cnt_r != 2'd0);
        if (dat_vld) begin
            dat_dat = head_s.dat[DW-1:0];
            dat_lst = head_s.lst;
        end else begin
            dat_dat = {DW{1'b0}};
            dat_lst = 1'b0;
        end
    end

endmodule

// File: rtl/eeg_xram_bank.sv
// EEG external-RAM bank: XRAM_NUM_DW independent RAM channels, each with a
// write port, a read-address port and a read-data port (valid/ready).
module eeg_xram_bank
    import eeg_xram_bank_pkg::*;
#(
    parameter int XRAM_NUM_DW  = 4,
    parameter int XRAM_ADD_AW  = 12,
    parameter int XRAM_DAT_DW  = 8,
    parameter int XRAM_RAW_FWD = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               PASS_DAT_ENA,
    input  logic [XRAM_NUM_DW-1:0]             XRAM_DIN_VLD,
    output logic [XRAM_NUM_DW-1:0]             XRAM_DIN_RDY,
    input  logic [XRAM_NUM_DW*XRAM_ADD_AW-1:0] XRAM_DIN_ADD,
    input  logic [XRAM_NUM_DW*XRAM_DAT_DW-1:0] XRAM_DIN_DAT,
    input  logic [XRAM_NUM_DW-1:0]             XRAM_ADD_VLD,
    input  logic [XRAM_NUM_DW-1:0]             XRAM_ADD_LST,
    output logic [XRAM_NUM_DW-1:0]             XRAM_ADD_RDY,
    input  logic [XRAM_NUM_DW*XRAM_ADD_AW-1:0] XRAM_ADD_ADD,
    output logic [XRAM_NUM_DW-1:0]             XRAM_DAT_VLD,
    output logic [XRAM_NUM_DW-1:0]             XRAM_DAT_LST,
    input  logic [XRAM_NUM_DW-1:0]             XRAM_DAT_RDY,
    output logic [XRAM_NUM_DW*XRAM_DAT_DW-1:0] XRAM_DAT_DAT
);

    for (genvar g = 0; g < XRAM_NUM_DW; g++) begin : g_chn
        eeg_xram_chn #(
            .AW      (XRAM_ADD_AW),
            .DW      (XRAM_DAT_DW),
            .RAW_FWD (XRAM_RAW_FWD)
        ) u_chn (
            .clk      (clk),
            .rst_n    (rst_n),
            .pass_ena (PASS_DAT_ENA),
            .din_vld  (XRAM_DIN_VLD[g]),
            .din_rdy  (XRAM_DIN_RDY[g]),
            .din_add  (XRAM_DIN_ADD[g*XRAM_ADD_AW +: XRAM_ADD_AW]),
            .din_dat  (XRAM_DIN_DAT[g*XRAM_DAT_DW +: XRAM_DAT_DW]),
            .add_vld  (XRAM_ADD_VLD[g]),
            .add_lst  (XRAM_ADD_LST[g]),
            .add_rdy  (XRAM_ADD_RDY[g]),
            .add_add  (XRAM_ADD_ADD[g*XRAM_ADD_AW +: XRAM_ADD_AW]),
            .dat_vld  (XRAM_DAT_VLD[g]),
            .dat_lst  (XRAM_DAT_LST[g]),
            .dat_rdy  (XRAM_DAT_RDY[g]),
            .dat_dat  (XRAM_DAT_DAT[g*XRAM_DAT_DW +: XRAM_DAT_DW])
        );
    end

endmodule

// File: tb/tb_eeg_xram_bank.sv
// Self-checking bench for eeg_xram_bank: a cycle model of each channel's
// credit/occupancy plus a RAM model feed per-channel expected-data queues.
// A second instance with forwarding disabled runs on the same stimulus.
module tb_eeg_xram_bank;
    localparam int NUM = 4;
    localparam int AW  = 12;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pass = 1'b0;
    logic [NUM-1:0]    din_vld = '0, add_vld = '0, add_lst = '0, dat_rdy = '0;
    logic [NUM*AW-1:0] din_add = '0, add_add = '0;
    logic [NUM*DW-1:0] din_dat = '0;
    logic [NUM-1:0]    din_rdy, add_rdy, dat_vld, dat_lst;
    logic [NUM-1:0]    din_rdy_nf, add_rdy_nf, dat_vld_nf, dat_lst_nf;
    logic [NUM*DW-1:0] dat_dat, dat_dat_nf;

    always #5 clk = ~clk;

    eeg_xram_bank #(.XRAM_NUM_DW(NUM), .XRAM_ADD_AW(AW), .XRAM_DAT_DW(DW), .XRAM_RAW_FWD(1)) dut (
        .clk(clk), .rst_n(rst_n), .PASS_DAT_ENA(pass),
        .XRAM_DIN_VLD(din_vld), .XRAM_DIN_RDY(din_rdy), .XRAM_DIN_ADD(din_add), .XRAM_DIN_DAT(din_dat),
        .XRAM_ADD_VLD(add_vld), .XRAM_ADD_LST(add_lst), .XRAM_ADD_RDY(add_rdy), .XRAM_ADD_ADD(add_add),
        .XRAM_DAT_VLD(dat_vld), .XRAM_DAT_LST(dat_lst), .XRAM_DAT_RDY(dat_rdy), .XRAM_DAT_DAT(dat_dat)
    );

    eeg_xram_bank #(.XRAM_NUM_DW(NUM), .XRAM_ADD_AW(AW), .XRAM_DAT_DW(DW), .XRAM_RAW_FWD(0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .PASS_DAT_ENA(pass),
        .XRAM_DIN_VLD(din_vld), .XRAM_DIN_RDY(din_rdy_nf), .XRAM_DIN_ADD(din_add), .XRAM_DIN_DAT(din_dat),
        .XRAM_ADD_VLD(add_vld), .XRAM_ADD_LST(add_lst), .XRAM_ADD_RDY(add_rdy_nf), .XRAM_ADD_ADD(add_add),
        .XRAM_DAT_VLD(dat_vld_nf), .XRAM_DAT_LST(dat_lst_nf), .XRAM_DAT_RDY(dat_rdy), .XRAM_DAT_DAT(dat_dat_nf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_mem [NUM][2**AW];
    logic [8:0]    q [NUM][$];
    logic [8:0]    qn [$];
    int            m_cnt [NUM];
    bit            m_s1 [NUM];
    bit            rst_prev = 1'b0;
    int            cyc = 0;
    int            pop_cyc [$];
    int            rdy_mode = 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Cycle model and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        for (int c = 0; c < NUM; c++) begin
            bit pop, credit, e_add, e_din, ar, aw;
            logic [8:0] e;
            logic [DW-1:0] old, wd;
            logic [AW-1:0] ra, wa;
            pop    = (m_cnt[c] != 0) && dat_rdy[c];
            credit = (m_cnt[c] + (m_s1[c] ? 1 : 0) - (pop ? 1 : 0)) < 2;
            e_add  = rst_n && !pass && credit;
            e_din  = rst_n && (pass ? credit : 1'b1);
            chk_eq("dat_vld", dat_vld[c], m_cnt[c] != 0);
            chk_eq("add_rdy", add_rdy[c], e_add);
            chk_eq("din_rdy", din_rdy[c], e_din);
            if (rst_prev) begin
                chk_eq("rst_dat", dat_dat[c*DW +: DW], 0);
                chk_eq("rst_lst", dat_lst[c], 0);
            end
            if (!rst_n) begin
                q[c].delete();
                if (c == 0) qn.delete();
                m_cnt[c] = 0;
                m_s1[c]  = 1'b0;
            end else begin
                if (pop) begin
                    if (q[c].size() == 0) begin
                        chk_eq("q_underrun", 1, 0);
                    end else begin
                        e = q[c].pop_front();
                        chk_eq("dat", dat_dat[c*DW +: DW], e[7:0]);
                        chk_eq("lst", dat_lst[c], e[8]);
                    end
                    if (c == 0) begin
                        pop_cyc.push_back(cyc);
                        if (qn.size() == 0) begin
                            chk_eq("qn_underrun", 1, 0);
                        end else begin
                            e = qn.pop_front();
                            chk_eq("dat_nofwd", dat_dat_nf[DW-1:0], e[7:0]);
                            chk_eq("dat_vld_nofwd", dat_vld_nf[0], 1);
                        end
                    end
                end
                ar = add_vld[c] && e_add;
                aw = din_vld[c] && e_din;
                ra = add_add[c*AW +: AW];
                wa = din_add[c*AW +: AW];
                wd = din_dat[c*DW +: DW];
                if (pass && aw) begin
                    q[c].push_back({1'b0, wd});
                    if (c == 0) qn.push_back({1'b0, wd});
                end else begin
                    if (ar) begin
                        old = m_mem[c][ra];
                        q[c].push_back({add_lst[c], (aw && wa == ra) ? wd : old});
                        if (c == 0) qn.push_back({add_lst[c], old});
                    end
                    if (aw) m_mem[c][wa] = wd;
                end
                m_cnt[c] = m_cnt[c] + (m_s1[c] ? 1 : 0) - (pop ? 1 : 0);
                m_s1[c]  = ar || (pass && aw);
            end
        end
        rst_prev = !rst_n;
    end

    // Read-data ready driver: 0 = hold low, 1 = hold high, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM; c++) begin
                dat_rdy[c] = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int c, input bit is_add);
        int t;
        bit ok;
        t = 0;
        do begin
            @(negedge clk);
            ok = is_add ? add_rdy[c] : din_rdy[c];
            step();
            t++;
        end while (!ok && t < 200);
        if (!ok) chk_eq("hs_timeout", 0, 1);
    endtask

    task automatic wr(input int c, input int a, input int d);
        logic [31:0] av, dv;
        av = a;
        dv = d;
        din_vld[c] = 1'b1;
        din_add[c*AW +: AW] = av[AW-1:0];
        din_dat[c*DW +: DW] = dv[DW-1:0];
        wait_acc(c, 1'b0);
        din_vld[c] = 1'b0;
    endtask

    task automatic rd_burst(input int c, input int base, input int n);
        logic [31:0] av;
        for (int i = 0; i < n; i++) begin
            av = base + i;
            add_vld[c] = 1'b1;
            add_add[c*AW +: AW] = av[AW-1:0];
            add_lst[c] = (i == n - 1);
            wait_acc(c, 1'b1);
        end
        add_vld[c] = 1'b0;
        add_lst[c] = 1'b0;
    endtask

    task automatic drain();
        int t, tot;
        t = 0;
        do begin
            step();
            tot = qn.size();
            for (int c = 0; c < NUM; c++) tot += q[c].size() + m_cnt[c] + (m_s1[c] ? 1 : 0);
            t++;
        end while (tot != 0 && t < 500);
        chk_eq("drain", tot, 0);
    endtask

    initial begin
        int n0;
        logic [31:0] dv;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single write then read back
        wr(0, 'h010, 'h5A);
        rd_burst(0, 'h010, 1);
        drain();

        // 16-word stream at full rate
        for (int i = 0; i < 16; i++) wr(0, i, (i * 29 + 7) & 255);
        drain();
        n0 = pop_cyc.size();
        rd_burst(0, 'h000, 16);
        drain();
        chk_eq("thru_cnt", pop_cyc.size() - n0, 16);
        if (pop_cyc.size() - n0 == 16) chk_eq("thru_span", pop_cyc[n0+15] - pop_cyc[n0], 15);

        // same stream under random backpressure
        rdy_mode = 2;
        rd_burst(0, 'h000, 16);
        rd_burst(0, 'h008, 4);
        drain();
        rdy_mode = 1;

        // same-cycle write and read of one address
        wr(0, 'h0FF, 'h11);
        drain();
        din_vld[0] = 1'b1;
        din_add[AW-1:0] = 12'h0FF;
        din_dat[DW-1:0] = 8'hC3;
        add_vld[0] = 1'b1;
        add_add[AW-1:0] = 12'h0FF;
        add_lst[0] = 1'b1;
        wait_acc(0, 1'b1);
        din_vld[0] = 1'b0;
        add_vld[0] = 1'b0;
        add_lst[0] = 1'b0;
        rd_burst(0, 'h0FF, 1);
        drain();

        // pass mode: data bypasses the RAM
        pass = 1'b1;
        for (int i = 1; i <= 3; i++) wr(0, 'h010, i);
        pass = 1'b0;
        drain();
        rd_burst(0, 'h010, 1);
        drain();

        // reset with two words pending
        rdy_mode = 0;
        rd_burst(0, 'h000, 2);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        rdy_mode = 1;
        step();
        rd_burst(0, 'h010, 1);
        rd_burst(0, 'h003, 1);
        drain();

        // channel independence
        wr(1, 'h010, 'hA5);
        rd_burst(1, 'h010, 1);
        rd_burst(0, 'h010, 1);
        for (int c = 0; c < NUM; c++) begin
            dv = 'h40 + c;
            wr(c, 'hFFF, dv);
        end
        for (int c = 0; c < NUM; c++) rd_burst(c, 'hFFF, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
